// File: rtl/mmio_port_bank_if.sv
// Data-bus connection between the core (master) and mmio_port_bank (slave).
// The core drives the address and strobes; the bank returns registered load data and a combinational window hit.
interface mmio_port_bank_if;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [3:0]  byteEnable;
    logic        writeEnable;
    logic        readEnable;
    logic [31:0] readData;
    logic        readValid;
    logic        addressHit;

    modport master (
        output address, writeData, byteEnable, writeEnable, readEnable,
        input  readData, readValid, addressHit
    );

    modport slave (
        input  address, writeData, byteEnable, writeEnable, readEnable,
        output readData, readValid, addressHit
    );
endinterface

// File: rtl/mmio_port_bank.sv
// Memory-mapped bank of NUM_PORTS 32-bit I/O ports with direction registers and synchronised inputs.
// Define MMIO_PORT_BANK_CHANGE_IRQ_EN to build the sticky change flags, irq mask and changeIrq output.
module mmio_port_bank #(
    parameter int unsigned NUM_PORTS   = 8,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFFFF00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    mmio_port_bank_if.slave         bus,
    input  logic [NUM_PORTS*32-1:0] portInput,
    output logic [NUM_PORTS*32-1:0] portOutput,
    output logic [NUM_PORTS*32-1:0] portDirection,
    output logic                    changeIrq
);
    localparam int unsigned WINDOW_WORDS = 2 * NUM_PORTS + 2;
    localparam logic [29:0] FLAG_OFF     = 30'(2 * NUM_PORTS);
    localparam logic [29:0] MASK_OFF     = 30'(2 * NUM_PORTS + 1);

    logic [31:0]             byte_off;
    logic [29:0]             word_off;
    logic                    hit;
    logic                    wr_hit;
    logic                    rd_hit;
    logic                    unused_addr_bits;
    logic [NUM_PORTS*32-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PORTS*32-1:0] sync_out;
    logic [NUM_PORTS*32-1:0] out_q;
    logic [NUM_PORTS*32-1:0] dir_q;
    logic [31:0]             read_word;
    logic [31:0]             rd_data_q;
    logic                    rd_valid_q;

    // Addresses below the base wrap to huge offsets, so one compare covers both window edges.
    assign byte_off         = bus.address - BASE_ADDR;
    assign word_off         = byte_off[31:2];
    assign unused_addr_bits = ^byte_off[1:0];
    assign hit              = (word_off < 30'(WINDOW_WORDS));
    assign wr_hit           = bus.writeEnable & hit;
    assign rd_hit           = bus.readEnable & hit;

    assign bus.addressHit = hit;
    assign bus.readData   = rd_data_q;
    assign bus.readValid  = rd_valid_q;
    assign portOutput     = out_q;
    assign portDirection  = dir_q;
    assign sync_out       = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= portInput;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
            dir_q <= '0;
        end else if (wr_hit) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                for (int k = 0; k < 4; k++) begin
                    if (bus.byteEnable[k]) begin
                        if (word_off == 30'(i)) begin
                            out_q[32*i+8*k +: 8] <= bus.writeData[8*k +: 8];
                        end
                        if (word_off == 30'(NUM_PORTS + i)) begin
                            dir_q[32*i+8*k +: 8] <= bus.writeData[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

`ifdef MMIO_PORT_BANK_CHANGE_IRQ_EN
    localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
    localparam int          CNT_W       = $clog2(WARM_CYCLES + 1);

    logic [CNT_W-1:0]        warm_cnt;
    logic                    warm_done;
    logic [NUM_PORTS*32-1:0] prev_sync;
    logic [NUM_PORTS-1:0]    flags_q;
    logic [NUM_PORTS-1:0]    mask_q;
    logic [NUM_PORTS-1:0]    set_bits;
    logic [NUM_PORTS-1:0]    flags_next;
    logic [NUM_PORTS-1:0]    mask_next;
    logic [31:0]             clear_word;
    logic [31:0]             mask_word;
    logic                    irq_q;
    logic                    unused_upper_bits;

    assign warm_done         = (warm_cnt == CNT_W'(WARM_CYCLES));
    assign unused_upper_bits = ^{clear_word, mask_word};

    // A new edge always beats a same-cycle write-1-to-clear.
    always_comb begin
        set_bits   = '0;
        clear_word = '0;
        mask_word  = 32'(mask_q);
        for (int i = 0; i < NUM_PORTS; i++) begin
            set_bits[i] = warm_done && (sync_out[32*i +: 32] != prev_sync[32*i +: 32]);
        end
        if (wr_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.byteEnable[k]) begin
                    if (word_off == FLAG_OFF) begin
                        clear_word[8*k +: 8] = bus.writeData[8*k +: 8];
                    end
                    if (word_off == MASK_OFF) begin
                        mask_word[8*k +: 8] = bus.writeData[8*k +: 8];
                    end
                end
            end
        end
        flags_next = (flags_q & ~clear_word[NUM_PORTS-1:0]) | set_bits;
        mask_next  = mask_word[NUM_PORTS-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            warm_cnt  <= '0;
            prev_sync <= '0;
            flags_q   <= '0;
            mask_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (!warm_done) begin
                warm_cnt <= warm_cnt + 1'b1;
            end
            prev_sync <= sync_out;
            flags_q   <= flags_next;
            mask_q    <= mask_next;
            irq_q     <= |(flags_q & mask_q);
        end
    end

    assign changeIrq = irq_q;
`else
    assign changeIrq = 1'b0;
`endif

    // Flag and mask offsets still hit without the irq feature; they simply read as zero.
    always_comb begin
        read_word = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (word_off == 30'(i)) begin
                read_word = sync_out[32*i +: 32];
            end
            if (word_off == 30'(NUM_PORTS + i)) begin
                read_word = dir_q[32*i +: 32];
            end
        end
`ifdef MMIO_PORT_BANK_CHANGE_IRQ_EN
        if (word_off == FLAG_OFF) begin
            read_word = 32'(flags_q);
        end
        if (word_off == MASK_OFF) begin
            read_word = 32'(mask_q);
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_hit;
            if (rd_hit) begin
                rd_data_q <= read_word;
            end
        end
    end

    always @(posedge clock) begin
        assert (BASE_ADDR[1:0] == 2'b00)
            else $error("mmio_port_bank: BASE_ADDR must be 4-byte aligned");
        assert (NUM_PORTS >= 1 && NUM_PORTS <= 32)
            else $error("mmio_port_bank: NUM_PORTS must be 1..32");
        assert (SYNC_STAGES >= 2)
            else $error("mmio_port_bank: SYNC_STAGES must be at least 2");
        assert (({1'b0, BASE_ADDR} + 33'(WINDOW_WORDS * 4)) <= 33'h1_0000_0000)
            else $error("mmio_port_bank: address window wraps past 32'hFFFFFFFF");
    end
endmodule

// File: tb/tb_mmio_port_bank.sv
// Randomised self-checking bench for mmio_port_bank against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_mmio_port_bank;
    localparam int          N     = 8;
    localparam int          S     = 2;
    localparam logic [31:0] BASE  = 32'hFFFFFF00;
    localparam int          WORDS = 2 * N + 2;
    localparam logic [31:0] PORT_BITS = (N >= 32) ? 32'hFFFFFFFF : 32'((64'd1 << N) - 64'd1);

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N*32-1:0] portInput;
    logic [N*32-1:0] portOutput;
    logic [N*32-1:0] portDirection;
    logic            changeIrq;

    mmio_port_bank_if bus ();

    mmio_port_bank #(.NUM_PORTS(N), .BASE_ADDR(BASE), .SYNC_STAGES(S)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus           (bus),
        .portInput     (portInput),
        .portOutput    (portOutput),
        .portDirection (portDirection),
        .changeIrq     (changeIrq)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Behavioural model: synced input is simply the input seen S edges ago.
    logic [31:0]     out_m [N];
    logic [31:0]     dir_m [N];
    logic [31:0]     flags_m, mask_m, rd_data_m;
    logic            rd_valid_m, irq_m;
    logic [N*32-1:0] hist [$];
    logic [N*32-1:0] prev_sync_m;
    int              edges_m;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            out_m[i] = '0;
            dir_m[i] = '0;
        end
        flags_m = '0; mask_m = '0; rd_data_m = '0; rd_valid_m = 1'b0; irq_m = 1'b0;
        hist.delete();
        for (int s = 0; s < S; s++) hist.push_back('0);
        prev_sync_m = '0;
        edges_m = 0;
    endfunction

    function automatic bit in_window(input logic [31:0] a);
        logic [31:0] d;
        d = a - BASE;
        return (d >> 2) < WORDS;
    endfunction

    function automatic logic [N*32-1:0] pack_out();
        logic [N*32-1:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = out_m[i];
        return v;
    endfunction

    function automatic logic [N*32-1:0] pack_dir();
        logic [N*32-1:0] v;
        for (int i = 0; i < N; i++) v[32*i +: 32] = dir_m[i];
        return v;
    endfunction

    function automatic void model_edge(input logic [31:0] a, input logic [31:0] wd,
                                       input logic [3:0] be, input logic we, input logic re);
        logic [31:0]     d, rv, clr, set_m;
        logic [N*32-1:0] cur;
        int              o;
        bit              hit;
        d   = a - BASE;
        hit = (d >> 2) < WORDS;
        o   = int'(d >> 2);
        cur = hist[0];
        rv  = '0;
        if (hit) begin
            if (o < N) rv = cur[32*o +: 32];
            else if (o < 2 * N) rv = dir_m[o-N];
`ifdef MMIO_PORT_BANK_CHANGE_IRQ_EN
            else if (o == 2 * N) rv = flags_m;
            else rv = mask_m;
`endif
        end
        rd_valid_m = re && hit;
        if (rd_valid_m) rd_data_m = rv;
`ifdef MMIO_PORT_BANK_CHANGE_IRQ_EN
        irq_m = |(flags_m & mask_m);
`endif
        set_m = '0;
        for (int i = 0; i < N; i++)
            set_m[i] = (edges_m >= S + 1) && (cur[32*i +: 32] != prev_sync_m[32*i +: 32]);
        clr = '0;
        if (we && hit) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    if (o < N) out_m[o][8*k +: 8] = wd[8*k +: 8];
                    else if (o < 2 * N) dir_m[o-N][8*k +: 8] = wd[8*k +: 8];
`ifdef MMIO_PORT_BANK_CHANGE_IRQ_EN
                    else if (o == 2 * N) clr[8*k +: 8] = wd[8*k +: 8];
                    else mask_m[8*k +: 8] = wd[8*k +: 8];
`endif
                end
            end
        end
`ifdef MMIO_PORT_BANK_CHANGE_IRQ_EN
        mask_m  = mask_m & PORT_BITS;
        flags_m = ((flags_m & ~clr) | set_m) & PORT_BITS;
`endif
        prev_sync_m = cur;
        hist.push_back(portInput);
        void'(hist.pop_front());
        edges_m++;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input logic we, input logic re);
        bus.address = a; bus.writeData = wd; bus.byteEnable = be;
        bus.writeEnable = we; bus.readEnable = re;
        #1;
    endtask

    task automatic advance();
        @(posedge clock);
        model_edge(bus.address, bus.writeData, bus.byteEnable, bus.writeEnable, bus.readEnable);
        @(negedge clock);
        bus.writeEnable = 1'b0;
        bus.readEnable  = 1'b0;
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                        input logic we, input logic re);
        drive(a, wd, be, we, re);
        advance();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(BASE, '0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.readData !== 32'h0) begin errors++; $display("[TB] FAIL reset_readData got %h expected %h", bus.readData, 32'h0); end
        checks++; if (bus.readValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_readValid got %b expected 0", bus.readValid); end
        checks++; if (portOutput !== '0) begin errors++; $display("[TB] FAIL reset_portOutput got %h expected 0", portOutput); end
        checks++; if (portDirection !== '0) begin errors++; $display("[TB] FAIL reset_portDirection got %h expected 0", portDirection); end
        checks++; if (changeIrq !== 1'b0) begin errors++; $display("[TB] FAIL reset_changeIrq got %b expected 0", changeIrq); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_byte_write();
        portInput[31:0] = 32'h0BADF00D;
        step(BASE, 32'hDEADBEEF, 4'b0101, 1'b1, 1'b0);
        checks++; if (portOutput[31:0] !== 32'h00AD00EF) begin errors++; $display("[TB] FAIL byte_write got %h expected %h", portOutput[31:0], 32'h00AD00EF); end
        idle(S - 1);
        step(BASE, '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readData !== 32'h0BADF00D) begin errors++; $display("[TB] FAIL read_port0_input got %h expected %h", bus.readData, 32'h0BADF00D); end
    endtask

    task automatic test_sync_read();
        portInput[127:96] = 32'h12345678;
        idle(S - 1);
        step(BASE + 32'd12, '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readData !== 32'h0) begin errors++; $display("[TB] FAIL sync_early got %h expected %h", bus.readData, 32'h0); end
        step(BASE + 32'd12, '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readValid !== 1'b1) begin errors++; $display("[TB] FAIL sync_valid got %b expected 1", bus.readValid); end
        checks++; if (bus.readData !== 32'h12345678) begin errors++; $display("[TB] FAIL sync_done got %h expected %h", bus.readData, 32'h12345678); end
    endtask

    task automatic test_direction();
        step(BASE + 32'(4 * N + 4), 32'hFFFF0000, 4'hF, 1'b1, 1'b0);
        checks++; if (portDirection[63:32] !== 32'hFFFF0000) begin errors++; $display("[TB] FAIL dir_write got %h expected %h", portDirection[63:32], 32'hFFFF0000); end
        step(BASE + 32'(4 * N + 4), '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readValid !== 1'b1) begin errors++; $display("[TB] FAIL dir_valid got %b expected 1", bus.readValid); end
        checks++; if (bus.readData !== 32'hFFFF0000) begin errors++; $display("[TB] FAIL dir_read got %h expected %h", bus.readData, 32'hFFFF0000); end
        idle(1);
        checks++; if (bus.readValid !== 1'b0) begin errors++; $display("[TB] FAIL dir_valid_pulse got %b expected 0", bus.readValid); end
        checks++; if (bus.readData !== 32'hFFFF0000) begin errors++; $display("[TB] FAIL dir_hold got %h expected %h", bus.readData, 32'hFFFF0000); end
    endtask

`ifdef MMIO_PORT_BANK_CHANGE_IRQ_EN
    task automatic test_change_irq();
        step(BASE + 32'(8 * N), 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
        step(BASE + 32'(8 * N + 4), 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
        step(BASE + 32'(8 * N + 4), '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readData !== PORT_BITS) begin errors++; $display("[TB] FAIL mask_width got %h expected %h", bus.readData, PORT_BITS); end
        step(BASE + 32'(8 * N + 4), 32'h4, 4'hF, 1'b1, 1'b0);
        portInput[64] = ~portInput[64];
        idle(S + 2);
        checks++; if (changeIrq !== 1'b1) begin errors++; $display("[TB] FAIL irq_set got %b expected 1", changeIrq); end
        step(BASE + 32'(8 * N), '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readData !== 32'h4) begin errors++; $display("[TB] FAIL flag_set got %h expected %h", bus.readData, 32'h4); end
        portInput[64] = ~portInput[64];
        idle(S);
        step(BASE + 32'(8 * N), 32'h4, 4'hF, 1'b1, 1'b0);
        step(BASE + 32'(8 * N), '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readData !== 32'h4) begin errors++; $display("[TB] FAIL set_beats_clear got %h expected %h", bus.readData, 32'h4); end
        step(BASE + 32'(8 * N), 32'h4, 4'hF, 1'b1, 1'b0);
        step(BASE + 32'(8 * N), '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readData !== 32'h0) begin errors++; $display("[TB] FAIL flag_clear got %h expected %h", bus.readData, 32'h0); end
        checks++; if (changeIrq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear got %b expected 0", changeIrq); end
    endtask
`else
    task automatic test_flags_absent();
        step(BASE + 32'(8 * N), 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
        step(BASE + 32'(8 * N + 4), 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
        step(BASE + 32'(8 * N), '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readValid !== 1'b1) begin errors++; $display("[TB] FAIL flag_off_valid got %b expected 1", bus.readValid); end
        checks++; if (bus.readData !== 32'h0) begin errors++; $display("[TB] FAIL flag_off_read got %h expected 0", bus.readData); end
        step(BASE + 32'(8 * N + 4), '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readData !== 32'h0) begin errors++; $display("[TB] FAIL mask_off_read got %h expected 0", bus.readData); end
        portInput[64] = ~portInput[64];
        idle(S + 3);
        checks++; if (changeIrq !== 1'b0) begin errors++; $display("[TB] FAIL irq_tied got %b expected 0", changeIrq); end
    endtask
`endif

    task automatic test_out_of_window();
        logic [N*32-1:0] out_before, dir_before;
        logic [31:0]     rd_before;
        logic [31:0]     addrs [2];
        step(BASE + 32'd4, 32'h5A5A5A5A, 4'hF, 1'b1, 1'b1);
        out_before = portOutput; dir_before = portDirection; rd_before = bus.readData;
        addrs[0] = BASE - 32'd4;
        addrs[1] = BASE + 32'(4 * WORDS);
        for (int j = 0; j < 2; j++) begin
            drive(addrs[j], 32'hFFFFFFFF, 4'hF, 1'b1, 1'b1);
            checks++; if (bus.addressHit !== 1'b0) begin errors++; $display("[TB] FAIL oow_hit addr %h got %b expected 0", addrs[j], bus.addressHit); end
            advance();
            checks++; if (bus.readValid !== 1'b0) begin errors++; $display("[TB] FAIL oow_valid addr %h got %b expected 0", addrs[j], bus.readValid); end
            checks++; if (bus.readData !== rd_before) begin errors++; $display("[TB] FAIL oow_rdhold got %h expected %h", bus.readData, rd_before); end
            checks++; if (portOutput !== out_before || portDirection !== dir_before) begin errors++; $display("[TB] FAIL oow_state got %h/%h expected %h/%h", portOutput, portDirection, out_before, dir_before); end
        end
        drive(BASE + 32'(4 * WORDS - 4) + 32'd3, '0, 4'h0, 1'b0, 1'b0);
        checks++; if (bus.addressHit !== 1'b1) begin errors++; $display("[TB] FAIL last_word_hit got %b expected 1", bus.addressHit); end
        advance();
    endtask

    task automatic test_powerup_hold();
        portInput[191:160] = 32'hFFFFFFFF;
        apply_reset();
        idle(S + 4);
        step(BASE + 32'(8 * N), '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readData !== 32'h0) begin errors++; $display("[TB] FAIL powerup_flags got %h expected 0", bus.readData); end
        checks++; if (changeIrq !== 1'b0) begin errors++; $display("[TB] FAIL powerup_irq got %b expected 0", changeIrq); end
        step(BASE + 32'd20, '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readData !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL powerup_port5 got %h expected %h", bus.readData, 32'hFFFFFFFF); end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          o, p;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 99) < 85) begin
                o = $urandom_range(0, WORDS - 1);
                a = BASE + 32'(4 * o) + 32'($urandom_range(0, 3));
            end else if ($urandom_range(0, 1) == 0) begin
                a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
            end else begin
                a = BASE + 32'(4 * (WORDS + $urandom_range(0, 3))) + 32'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(0, N - 1);
                portInput[32*p + $urandom_range(0, 31)] ^= 1'b1;
            end
            if ($urandom_range(0, 19) == 0) portInput[32*$urandom_range(0, N - 1) +: 32] = $urandom;
            drive(a, $urandom, 4'($urandom), 1'($urandom), 1'($urandom));
            checks++; if (bus.addressHit !== in_window(a)) begin errors++; $display("[TB] FAIL rand_hit cyc %0d addr %h got %b expected %b", c, a, bus.addressHit, in_window(a)); end
            advance();
            checks++; if (bus.readValid !== rd_valid_m) begin errors++; $display("[TB] FAIL rand_valid cyc %0d got %b expected %b", c, bus.readValid, rd_valid_m); end
            checks++; if (bus.readData !== rd_data_m) begin errors++; $display("[TB] FAIL rand_data cyc %0d got %h expected %h", c, bus.readData, rd_data_m); end
            checks++; if (portOutput !== pack_out()) begin errors++; $display("[TB] FAIL rand_out cyc %0d got %h expected %h", c, portOutput, pack_out()); end
            checks++; if (portDirection !== pack_dir()) begin errors++; $display("[TB] FAIL rand_dir cyc %0d got %h expected %h", c, portDirection, pack_dir()); end
            checks++; if (changeIrq !== irq_m) begin errors++; $display("[TB] FAIL rand_irq cyc %0d got %b expected %b", c, changeIrq, irq_m); end
        end
    endtask

    task automatic test_reset_midread();
        step(BASE, 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
        step(BASE + 32'(4 * N), 32'hFFFFFFFF, 4'hF, 1'b1, 1'b0);
`ifdef MMIO_PORT_BANK_CHANGE_IRQ_EN
        step(BASE + 32'(8 * N + 4), 32'hFF, 4'hF, 1'b1, 1'b0);
        portInput[0] = ~portInput[0];
        idle(S + 2);
        checks++; if (changeIrq !== 1'b1) begin errors++; $display("[TB] FAIL pre_reset_irq got %b expected 1", changeIrq); end
`endif
        step(BASE + 32'(4 * N), '0, 4'h0, 1'b0, 1'b1);
        checks++; if (bus.readValid !== 1'b1 || bus.readData !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL pre_reset_read got %b/%h expected 1/%h", bus.readValid, bus.readData, 32'hFFFFFFFF); end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        checks++; if (bus.readValid !== 1'b0) begin errors++; $display("[TB] FAIL async_valid got %b expected 0", bus.readValid); end
        checks++; if (bus.readData !== 32'h0) begin errors++; $display("[TB] FAIL async_data got %h expected 0", bus.readData); end
        checks++; if (portOutput !== '0 || portDirection !== '0) begin errors++; $display("[TB] FAIL async_ports got %h/%h expected 0/0", portOutput, portDirection); end
        checks++; if (changeIrq !== 1'b0) begin errors++; $display("[TB] FAIL async_irq got %b expected 0", changeIrq); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t expected finish earlier", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        portInput = '0;
        bus.address = BASE; bus.writeData = '0; bus.byteEnable = '0;
        bus.writeEnable = 1'b0; bus.readEnable = 1'b0;
        test_reset();
        test_byte_write();
        test_sync_read();
        test_direction();
`ifdef MMIO_PORT_BANK_CHANGE_IRQ_EN
        test_change_irq();
`else
        test_flags_absent();
`endif
        test_out_of_window();
        test_powerup_hold();
        test_random();
        test_reset_midread();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmio_port_bank.md
Name: mmio_port_bank

Overview:
- Parametrised memory-mapped I/O port bank for the JZJCoreF memory subsystem.
- Generalises the fixed eight 32-bit in/out ports to NUM_PORTS ports and a relocatable address window.
- Adds per-byte write enables, per-port direction registers, input synchronisers, registered reads and sticky change flags with an optional interrupt.
- Sits beside RAM on the core's data bus; the core's read mux selects this block's readData when addressHit is set.

Parameters:
- NUM_PORTS, 8: number of 32-bit ports; legal range 1..32.
- BASE_ADDR, 32'hFFFFFF00: byte address of word offset 0; must be 4-byte aligned.
- SYNC_STAGES, 2: flip-flop stages on each input bit; minimum 2.

Ports:
- clock  in  1  system clock; all state is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- address  in  32  byte address from the core; bits [1:0] ignored.
- writeData  in  32  store data; byte lane k is bits [8k+7:8k].
- byteEnable  in  4  per-lane write enable.
- writeEnable  in  1  store strobe.
- readEnable  in  1  load strobe.
- readData  out  32  registered load data.
- readValid  out  1  readData valid this cycle.
- addressHit  out  1  combinational: address falls inside the window.
- portInput  in  NUM_PORTS*32  raw inputs; port i is bits [32i+31:32i].
- portOutput  out  NUM_PORTS*32  output registers.
- portDirection  out  NUM_PORTS*32  direction registers; 1 = drive; consumed by external tristate logic.
- changeIrq  out  1  level interrupt.

Behaviour:
- Word offset o = (address - BASE_ADDR) >> 2.
- Map:
  - o in 0..N-1: read gives synchronised input of port o; write updates output register o.
  - o in N..2N-1: direction register o-N, read/write.
  - o = 2N: change flags, bit i = port i; read, write-1-to-clear; bits >= N read 0.
  - o = 2N+1: irq mask, bit i enables port i; read/write.
- addressHit = 1 for offsets 0..2N+1, 0 otherwise.
- Accesses without a hit are ignored and do not assert readValid.
- Writes: registered on the strobe cycle; only lanes with byteEnable set change. Byte enables apply to flags and mask as well.
- Reads: 1-cycle latency.
  - readEnable & hit in cycle T: readData and readValid appear in T+1.
  - Otherwise readValid = 0 and readData holds its last value.
- Same-cycle read and write to the same offset: read returns the pre-write value.
- Synchroniser: SYNC_STAGES flops per bit, all reset to 0. Input reads return the last stage.
- Change detect: flag i sets when port i's last sync stage differs from its value one cycle earlier.
  - Flag set wins over a same-cycle W1C clear.
- Warm-up counter: detection is disabled for SYNC_STAGES+1 cycles after reset deasserts, so the post-reset load of a nonzero input does not set flags.
  - Counter saturates after warm-up.
- Reset values: portOutput 0, portDirection 0, flags 0, mask 0, readData 0, readValid 0, changeIrq 0, warm-up counter 0.
- Asserting reset mid-transaction aborts it; a pending readValid is dropped.
- Assertion checks: BASE_ADDR aligned; NUM_PORTS in 1..32; window does not wrap past 32'hFFFFFFFF.

Optional Feature:
- Macro: MMIO_PORT_BANK_CHANGE_IRQ_EN.
- Defined: changeIrq = |(flags & mask), registered, 1 cycle after the flag sets.
- Undefined:
  - Change-detect logic, warm-up counter, flags and mask are not built.
  - Offsets 2N and 2N+1 still hit but read 0; writes to them are ignored.
  - changeIrq is tied 0.

Test Plan:
- Reset, then write 32'hDEADBEEF to BASE_ADDR with byteEnable=4'b0101 -> portOutput[31:0] = 32'h00AD00EF; read back BASE_ADDR+0 returns the synchronised input, not the output register.
- Drive portInput port 3 = 32'h12345678, wait SYNC_STAGES cycles, readEnable at BASE_ADDR+12 -> readValid=1 one cycle later with readData=32'h12345678; same read one cycle before sync completes -> old value 0.
- Write 32'hFFFF0000 to BASE_ADDR+4N+4 (direction port 1) -> portDirection[63:32]=32'hFFFF0000; read back equal; readValid high exactly 1 cycle.
- (IRQ_EN) mask=8'h04, toggle port 2 bit 0 after warm-up -> flag bit 2 set, changeIrq=1; W1C 32'h4 in the same cycle as another toggle -> flag stays 1; W1C with no edge -> flag 0, changeIrq 0 next cycle.
- Hold port 5 = 32'hFFFFFFFF through reset release -> no flag after warm-up; access to BASE_ADDR-4 and BASE_ADDR+4(2N+2) -> addressHit=0, no readValid, no state change.
- Assert reset during a pending read with outputs nonzero -> readValid=0, all outputs 0 immediately, without waiting for a clock edge.
